// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - request/response handshake bundle for alu_exec_unit
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output operation, a, b, in_valid, out_ready,
    input  in_ready, result, zero, ovf, out_valid
  );

  modport slave (
    input  operation, a, b, in_valid, out_ready,
    output in_ready, result, zero, ovf, out_valid
  );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - single-issue ALU, 1-cycle ops plus optional 32-cycle shift-add MUL
// Optional multiplier enabled by defining ALU_EXEC_MUL_EN.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  alu_exec_unit_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;

  logic             accept;
  logic             is_mul;
  logic             idle;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;
  logic             out_valid_q;

`ifdef ALU_EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd3;

  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t           state;
  state_t           state_next;
  logic [5:0]       count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  assign is_mul = (bus.operation == OP_MUL);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) state <= IDLE;
    else                 state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept && is_mul) state_next = MUL_BUSY;
      MUL_BUSY: if (count == 6'd31) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    idle     = (state == IDLE);
    mul_done = (state == MUL_BUSY) && (count == 6'd31);
  end

  // Multiplicand shifts left and multiplier right, so bit 0 is always the current multiplier bit.
  assign mul_product = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= 6'd0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (flush) begin
      count <= 6'd0;
    end else if (accept && is_mul) begin
      count  <= 6'd0;
      mcand  <= bus.a;
      mplier <= bus.b;
      acc    <= '0;
    end else if (state == MUL_BUSY) begin
      acc    <= mul_product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= mul_done ? 6'd0 : count + 6'd1;
    end
  end
`else
  assign is_mul      = 1'b0;
  assign idle        = 1'b1;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  assign bus.in_ready = idle && (!out_valid_q || bus.out_ready) && !flush;
  assign accept       = bus.in_valid && bus.in_ready;

  assign sum  = bus.a + bus.b;
  assign diff = bus.a - bus.b;

  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (bus.operation)
      OP_ADD: begin
        alu_result = sum;
        alu_ovf    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_result = diff;
        alu_ovf    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_result = bus.a & bus.b;
      OP_OR:   alu_result = bus.a | bus.b;
      OP_SRL:  alu_result = bus.a >> bus.b[4:0];
      OP_SLL:  alu_result = bus.a << bus.b[4:0];
      default: alu_result = '0;
    endcase
  end

  // A consumed result is replaced in the same edge when a new single-cycle op is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      if (accept && !is_mul) begin
        result_q    <= alu_result;
        zero_q      <= (alu_result == '0);
        ovf_q       <= alu_ovf;
        out_valid_q <= 1'b1;
      end else if (mul_done) begin
        result_q    <= mul_product;
        zero_q      <= (mul_product == '0);
        ovf_q       <= 1'b0;
        out_valid_q <= 1'b1;
      end
    end
  end

  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 flush  input  1  synchronous pipeline flush; discards in-flight and held results.
REQ-005 operation  input  4  ALU opcode: 0000 NOP, 0001 ADD, 0010 SUB, 0011 MUL, 0100 AND, 0101 OR, 0110 SRL, 0111 SLL; 1000-1111 reserved.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B; b[4:0] is the shift amount for SRL/SLL.
REQ-008 in_valid  input  1  operation/a/b valid.
REQ-009 in_ready  output  1  unit accepts the request this cycle.
REQ-010 result  output  WIDTH  registered result.
REQ-011 zero  output  1  high when result == 0.
REQ-012 ovf  output  1  signed overflow for ADD/SUB; 0 for all other ops.
REQ-013 out_valid  output  1  result/zero/ovf valid.
REQ-014 out_ready  input  1  downstream consumes result this cycle.

Function
REQ-015 Request SHALL be accepted on a rising edge when in_valid && in_ready.
REQ-016 in_ready SHALL be high exactly when state == IDLE and (out_valid == 0 or out_ready == 1).
REQ-017 States: IDLE, MUL_BUSY. Transitions:
- IDLE->MUL_BUSY on acceptance of MUL.
- MUL_BUSY->IDLE on the 32nd iteration edge.
- flush or reset: any state->IDLE.
REQ-018 Non-MUL ops: result, zero and ovf SHALL be loaded on the accepting edge; out_valid high from the next cycle (latency 1).
REQ-019 ADD/SUB SHALL be WIDTH-bit wrap-around two's complement. ovf = operand signs equal (ADD) or differing (SUB) and result sign differs from a.
REQ-020 SRL SHALL be a logical right shift by b[4:0] with zero fill; SLL a left shift by b[4:0] with zero fill.
REQ-021 NOP and reserved opcodes SHALL produce result = 0, zero = 1, ovf = 0, and still assert out_valid (latency 1).
REQ-022 MUL SHALL be iterative shift-add, one multiplier bit per cycle, 6-bit iteration counter 0..31. result = low WIDTH bits of a*b (unsigned).
REQ-023 MUL timing: out_valid SHALL rise 32 cycles after the accepting edge. in_ready SHALL be low throughout MUL_BUSY.
REQ-024 Operands SHALL be captured on acceptance; input changes during MUL_BUSY have no effect.
REQ-025 out_valid SHALL stay high and result/zero/ovf stable until out_valid && out_ready. It then clears, unless a new non-MUL request is accepted in the same cycle, in which case out_valid stays high with the new result.
REQ-026 flush SHALL, on the next edge: abort MUL_BUSY, clear out_valid, and ignore in_valid that cycle. flush is outranked only by rst_n.
REQ-027 in_ready SHALL be low in any cycle with flush high.

Reset
REQ-028 rst_n low at an edge SHALL force: state = IDLE, counter = 0, result = 0, zero = 0, ovf = 0, out_valid = 0.
REQ-029 Reset asserted mid-MUL SHALL abort the multiply with no output. in_ready SHALL be high in the first cycle after rst_n deasserts.

Configuration
REQ-030 Macro ALU_EXEC_MUL_EN present: MUL behaves per REQ-022/023.
REQ-031 Macro ALU_EXEC_MUL_EN absent: no multiplier or MUL_BUSY logic. MUL is treated as a reserved opcode per REQ-021 (latency 1, result 0).

Verification
REQ-032 ADD a=0x7FFFFFFF, b=1 -> next cycle result=0x80000000, ovf=1, zero=0, out_valid=1.
REQ-033 SUB a=5, b=5 with out_ready held high -> result=0, zero=1, ovf=0. A back-to-back OR a=0xF0, b=0x0F accepted the following cycle -> result=0xFF, out_valid continuously high.
REQ-034 MUL a=0x10001, b=0x10001 (ALU_EXEC_MUL_EN defined) -> in_ready low 32 cycles, out_valid 32 cycles after accept, result=0x00020001.
REQ-035 SLL a=1, b=0x3F -> result=0x80000000. SRL a=0x80000000, b=31 -> result=1.
REQ-036 out_ready held low 5 cycles after ADD result -> result stable, in_ready low. Releasing out_ready -> transfer occurs, in_ready high.
REQ-037 Accept MUL, assert flush at cycle 10 -> out_valid never rises, in_ready high the cycle after flush. Repeat with rst_n=0 instead of flush -> all outputs 0.
